// File: rtl/lc3b_dmem_responder.sv
// LC-3b data-memory responder: services read/write requests from an internal
// 16-bit word array after LATENCY busy cycles and answers with a one-cycle
// mem_resp pulse.
//
// Ports:
//   clk             - single clock, rising edge
//   reset_n         - synchronous active-low reset
//   mem_read        - read request, held until mem_resp
//   mem_write       - write request, held until mem_resp (wins over read)
//   mem_address     - byte address; word index = mem_address[WORDS_LOG2:1]
//   mem_wdata       - write data
//   mem_byte_enable - write byte enables ([1] -> [15:8], [0] -> [7:0])
//   mem_resp        - registered one-cycle completion pulse
//   mem_rdata       - registered read data, valid while mem_resp is high
//   busy            - registered, high while in BUSY or RESP
module lc3b_dmem_responder #(
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned WORDS_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** WORDS_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    is_write_q, is_write_d;
  logic [WORDS_LOG2-1:0]   idx_q, idx_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [1:0]              be_q, be_d;

  logic                    resp_q, resp_d;
  logic                    busy_q, busy_d;
  logic [15:0]             rdata_q, rdata_d;
  logic                    commit_c;
  logic                    mem_we_c;

  logic [15:0]             mem_q [DEPTH];

  // Only the word-index bits of the address are used.
  logic                    unused_addr;
  assign unused_addr = ^mem_address;

  // State and request registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
    end
  end

  // Next-state, counter and request capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          state_d    = S_BUSY;
          cnt_d      = CNT_W'(LATENCY - 1);
          is_write_d = mem_write;
          idx_d      = mem_address[WORDS_LOG2:1];
          wdata_d    = mem_wdata;
          be_d       = mem_byte_enable;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next-values; the access completes on the BUSY->RESP edge.
  always_comb begin
    commit_c = (state_q == S_BUSY) && (state_d == S_RESP);
    mem_we_c = commit_c && is_write_q;
    resp_d   = (state_d == S_RESP);
    busy_d   = (state_d != S_IDLE);
    rdata_d  = rdata_q;
    if (commit_c && !is_write_q) begin
      rdata_d = mem_q[idx_q];
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Word array, not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we_c) begin
      if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lc3b_dmem_responder.sv
// Directed bench for lc3b_dmem_responder: table-driven accesses plus
// hand-written reset, held-request and reset-during-access sequences.
module tb_lc3b_dmem_responder;

  localparam int unsigned LAT = 3;
  localparam int unsigned WL2 = 8;

  logic        clk;
  logic        reset_n;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        busy;

  int tests;
  int fails;

  lc3b_dmem_responder #(.LATENCY(LAT), .WORDS_LOG2(WL2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  logic [15:0] last_rdata;
  bit          last_valid;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive a request at a negedge, wait for the response, drop the request in
  // the RESP cycle and verify the following IDLE cycle. Returns at that negedge.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        input string name, output logic [15:0] got);
    int  n;
    bit  found;
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wdata;
    mem_byte_enable = be;
    found = 0;
    n     = 0;
    got   = 16'h0000;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n = i;
      if (i == 1) check({name, " busy_rise"}, 16'(busy), 16'd1);
      if (mem_resp) begin
        found = 1;
        break;
      end
    end
    check({name, " resp_latency"}, found ? 16'(n) : 16'hFFFF, 16'(LAT + 1));
    got             = mem_rdata;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    @(negedge clk);
    check({name, " idle_resp"}, 16'(mem_resp), 16'd0);
    check({name, " idle_busy"}, 16'(busy), 16'd0);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [1:0] be,
                              input logic [15:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.exp = exp;
    return v;
  endfunction

  initial begin
    logic [15:0] got;
    int          resp_cycles [2];
    int          nresp;
    bit          saw_resp;

    tests = 0;
    fails = 0;
    last_valid = 0;
    last_rdata = 16'h0000;

    vecs[0]  = mk(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000);
    vecs[1]  = mk(1'b1, 1'b0, 16'h0011, 16'h0000, 2'b00, 16'hBEEF);
    vecs[2]  = mk(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 16'h0000);
    vecs[3]  = mk(1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 16'h0000);
    vecs[4]  = mk(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hAB34);
    vecs[5]  = mk(1'b0, 1'b1, 16'h0021, 16'h00FF, 2'b00, 16'h0000);
    vecs[6]  = mk(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hAB34);
    vecs[7]  = mk(1'b0, 1'b1, 16'h0030, 16'h0000, 2'b11, 16'h0000);
    vecs[8]  = mk(1'b0, 1'b1, 16'h0030, 16'h5A5A, 2'b01, 16'h0000);
    vecs[9]  = mk(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 16'h005A);
    vecs[10] = mk(1'b0, 1'b1, 16'h0200, 16'hCAFE, 2'b11, 16'h0000);
    vecs[11] = mk(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'hCAFE);
    vecs[12] = mk(1'b1, 1'b1, 16'h0040, 16'h1111, 2'b11, 16'h0000);
    vecs[13] = mk(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h1111);
    vecs[14] = mk(1'b0, 1'b1, 16'h0050, 16'h2222, 2'b11, 16'h0000);

    // Reset held two cycles with a read pending.
    reset_n         = 1'b0;
    mem_read        = 1'b1;
    mem_write       = 1'b0;
    mem_address     = 16'h0010;
    mem_wdata       = 16'h0000;
    mem_byte_enable = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset resp", 16'(mem_resp), 16'd0);
      check("reset busy", 16'(busy), 16'd0);
      check("reset rdata", mem_rdata, 16'h0000);
    end
    reset_n = 1'b1;
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "first_capture", got);

    // Table of single accesses.
    for (int i = 0; i < NVEC; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, nm, got);
      if (vecs[i].wr) begin
        if (last_valid) check({nm, " rdata_hold"}, got, last_rdata);
      end else begin
        check({nm, " rdata"}, got, vecs[i].exp);
        last_rdata = vecs[i].exp;
        last_valid = 1;
      end
    end

    // Held read across two accesses (LDI pattern), address noise during BUSY.
    mem_read    = 1'b1;
    mem_address = 16'h0040;
    nresp = 0;
    resp_cycles[0] = 0;
    resp_cycles[1] = 0;
    for (int c = 1; c <= 14 && nresp < 2; c++) begin
      @(negedge clk);
      if (mem_resp) begin
        if (nresp == 0) check("ldi first rdata", mem_rdata, 16'h1111);
        else            check("ldi second rdata", mem_rdata, 16'h2222);
        resp_cycles[nresp] = c;
        nresp++;
      end
      if (c == 2) mem_address = 16'h0010;
      if (c == 5) mem_address = 16'h0050;
      if (c == 7) mem_address = 16'h0020;
    end
    mem_read = 1'b0;
    check("ldi resp count", 16'(nresp), 16'd2);
    check("ldi first latency", 16'(resp_cycles[0]), 16'(LAT + 1));
    check("ldi spacing", 16'(resp_cycles[1] - resp_cycles[0]), 16'(LAT + 2));
    @(negedge clk);

    // Reset in the second BUSY cycle aborts a write.
    access(1'b0, 1'b1, 16'h0080, 16'h7777, 2'b11, "pre_abort", got);
    mem_write       = 1'b1;
    mem_address     = 16'h0080;
    mem_wdata       = 16'h5555;
    mem_byte_enable = 2'b11;
    @(negedge clk);
    @(negedge clk);
    reset_n   = 1'b0;
    mem_write = 1'b0;
    saw_resp  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) reset_n = 1'b1;
      if (mem_resp) saw_resp = 1;
    end
    check("abort no resp", 16'(saw_resp), 16'd0);
    access(1'b1, 1'b0, 16'h0080, 16'h0000, 2'b00, "post_abort", got);
    check("abort rdata", got, 16'h7777);

    // Reset in the RESP cycle keeps the committed write.
    mem_write       = 1'b1;
    mem_address     = 16'h0090;
    mem_wdata       = 16'h4242;
    mem_byte_enable = 2'b11;
    saw_resp = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_resp) begin
        saw_resp = 1;
        break;
      end
    end
    check("resp_reset resp seen", 16'(saw_resp), 16'd1);
    mem_write = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    check("resp_reset busy", 16'(busy), 16'd0);
    reset_n = 1'b1;
    access(1'b1, 1'b0, 16'h0090, 16'h0000, 2'b00, "post_resp_reset", got);
    check("resp_reset rdata", got, 16'h4242);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lc3b_dmem_responder.md
# lc3b_dmem_responder

Memory-side responder for the LC-3b datapath's data port. It accepts `mem_read`/`mem_write` requests from the pipeline's memory stage and services them from an internal word array after a fixed, parameterised latency. It signals completion with a one-cycle `mem_resp` pulse. The memory-stage sequencer, including its multi-access LDI/STI sequences, advances on that pulse.

## Interface
- `LATENCY`, default 3: cycles spent in BUSY per access; legal range 1..15.
- `WORDS_LOG2`, default 8: log2 of array depth in 16-bit words.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `mem_read` in 1: read request; held by the initiator until `mem_resp`.
- `mem_write` in 1: write request; held by the initiator until `mem_resp`.
- `mem_address` in 16: byte address. Bit 0 is ignored; word index is `mem_address[WORDS_LOG2:1]`; upper bits are ignored (wraps modulo depth).
- `mem_wdata` in 16: write data.
- `mem_byte_enable` in 2: write byte enables; bit 1 covers [15:8], bit 0 covers [7:0].
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_rdata` out 16: read data; valid only while `mem_resp` is high.
- `busy` out 1: high in BUSY and RESP.

## Operation
- States are IDLE, BUSY and RESP.
- **IDLE**
  - If `mem_read | mem_write` is high, capture the operation, word index, `mem_wdata` and `mem_byte_enable` into request registers, load `cnt` = LATENCY-1 and go to BUSY. Otherwise stay in IDLE.
  - If both `mem_read` and `mem_write` are high, the write wins and no read is performed.
- **BUSY**
  - Inputs are ignored; the captured request is authoritative.
  - If `cnt` == 0, go to RESP; otherwise decrement `cnt`.
  - On the BUSY→RESP edge:
    - Read: `mem_rdata` is loaded with array[index].
    - Write: array[index] is updated per byte enable. A byte enable of 2'b00 is a legal no-op write that still responds.
- **RESP**
  - `mem_resp` is high for exactly this cycle; next state is always IDLE.
  - On a write, `mem_rdata` holds its previous value.
- **Back-to-back requests:** a request still asserted in the IDLE cycle after RESP is a new request.
  - This is required so the initiator can keep `mem_read` high across the two LDI accesses while changing `mem_address`.
  - The second access samples the address present in that IDLE cycle.
- **Array**
  - Not reset; contents are undefined until written.
  - Reads ignore byte enables and return the full word.
- **Reset**
  - When `reset_n` is low at a rising edge:
    - state goes to IDLE;
    - `cnt` is cleared to 0;
    - `mem_resp` is 0, `busy` is 0 and `mem_rdata` is 16'h0000.
  - A reset during BUSY aborts the access with no array update and no response.
  - A reset in the RESP cycle leaves the already-committed write in the array.

## Timing
- Edge 0 is the edge at which IDLE samples a request.
- BUSY occupies cycles 1..LATENCY.
- `mem_resp` is high in cycle LATENCY+1.
- The earliest next capture is at the edge ending cycle LATENCY+2 (the IDLE cycle).
- Request-to-request throughput is LATENCY+2 cycles.
- `mem_resp` is never high on two consecutive cycles.
- `busy` rises the cycle after capture and falls in the IDLE cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles with `mem_read`=1 → `mem_resp`=0, `busy`=0 and `mem_rdata`=0 throughout; the first capture is on the first edge with `reset_n`=1.
- **Write then read, LATENCY=3:**
  - Write 16'hBEEF to address 16'h0010 with byte enable 2'b11 → `mem_resp` pulses 4 cycles after capture.
  - Then read address 16'h0011 → `mem_rdata`=16'hBEEF during the `mem_resp` cycle.
- **Partial write:**
  - Write 16'h1234 with byte enable 2'b11, then write 16'hAB00 with byte enable 2'b10 to the same word.
  - Reading that word returns 16'hAB34.
- **Held request (LDI pattern):**
  - Keep `mem_read`=1 throughout; present address A, then switch to address B in the cycle after the first `mem_resp`.
  - Expect two responses 5 cycles apart; the second returns the word at B.
  - Changes to `mem_address` during BUSY are ignored.
- **Read and write together:** `mem_read` and `mem_write` both high → the write is committed and `mem_rdata` is unchanged at `mem_resp`.
- **Reset mid-access:**
  - Assert `reset_n`=0 in the second BUSY cycle of a write of 16'h5555 over a word holding 16'h7777.
  - Expect no `mem_resp`, and a subsequent read of that word returns 16'h7777.
